// File: rtl/core_cache_req_buf.sv
// Request front end between the core load/store pipeline and the data cache.
// Stores post into an in-order write buffer; loads take priority unless they hit a buffered store.
module core_cache_req_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_AW   = 8,
  parameter int OFFSET_AW  = 4,
  parameter int DEPTH      = 4,
  localparam int TAG_W     = ADDR_WIDTH - INDEX_AW - OFFSET_AW,
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr_i,
  input  logic                  cpu_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] cpu_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
  input  logic [BE_W-1:0]       cpu_wr_en_i,
  output logic [DATA_WIDTH-1:0] cpu_rd_data_o,
  output logic                  cpu_rd_valid_o,
  output logic                  pipeline_stall_o,
  output logic                  wbuf_empty_o,
  output logic                  cache_req_o,
  output logic                  cache_op_o,
  output logic [INDEX_AW-1:0]   cache_index_o,
  output logic [TAG_W-1:0]      cache_tag_o,
  output logic [OFFSET_AW-1:0]  cache_offset_o,
  output logic [BE_W-1:0]       cache_wr_en_o,
  output logic [DATA_WIDTH-1:0] cache_wr_data_o,
  input  logic [DATA_WIDTH-1:0] cache_rd_data_i,
  input  logic                  cache_addr_ack_i,
  input  logic                  cache_data_ack_i
);

  localparam int WORD_LSB = $clog2(BE_W);
  localparam int PW       = $clog2(DEPTH);
  localparam int CW       = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RDATA, S_WDATA, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [BE_W-1:0]       mem_be_q   [DEPTH];

  logic          full, push, pop, wr_in_flight;
  logic          entry_hit, rd_hazard;
  logic [PW-1:0] rel;

  assign full         = (count_q == CW'(DEPTH));
  assign push         = cpu_wr_req_i && (!full || pop);
  assign wr_in_flight = ((state_q == S_ADDR) && op_q) || (state_q == S_WDATA);

  // Word-granular match against every live entry, the write on the bus and a same-cycle store.
  always_comb begin
    entry_hit = 1'b0;
    rel       = '0;
    for (int j = 0; j < DEPTH; j++) begin
      rel = PW'(j) - rd_ptr_q;
      if (({1'b0, rel} < count_q) &&
          (mem_addr_q[j][ADDR_WIDTH-1:WORD_LSB] == cpu_rd_addr_i[ADDR_WIDTH-1:WORD_LSB]))
        entry_hit = 1'b1;
    end
    rd_hazard = entry_hit ||
                (wr_in_flight && (addr_q[ADDR_WIDTH-1:WORD_LSB] == cpu_rd_addr_i[ADDR_WIDTH-1:WORD_LSB])) ||
                (cpu_wr_req_i && (cpu_wr_addr_i[ADDR_WIDTH-1:WORD_LSB] == cpu_rd_addr_i[ADDR_WIDTH-1:WORD_LSB]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      rd_data_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      rd_data_q <= rd_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= cpu_wr_addr_i;
      mem_data_q[wr_ptr_q] <= cpu_wr_data_i;
      mem_be_q[wr_ptr_q]   <= cpu_wr_en_i;
    end
  end

  // Cache handshake: cache_req_o stays high with stable fields until cache_addr_ack_i;
  // cache_data_ack_i then completes the transaction and may coincide with the address ack.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    rd_data_d = rd_data_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_rd_req_i && !rd_hazard) begin
          op_d    = 1'b0;
          addr_d  = cpu_rd_addr_i;
          data_d  = '0;
          be_d    = '0;
          state_d = S_ADDR;
        end else if (count_q != '0) begin
          op_d    = 1'b1;
          addr_d  = mem_addr_q[rd_ptr_q];
          data_d  = mem_data_q[rd_ptr_q];
          be_d    = mem_be_q[rd_ptr_q];
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cache_addr_ack_i) begin
          if (cache_data_ack_i) begin
            if (op_q) begin
              pop     = 1'b1;
              state_d = S_IDLE;
            end else begin
              rd_data_d = cache_rd_data_i;
              state_d   = S_RESP;
            end
          end else begin
            state_d = op_q ? S_WDATA : S_RDATA;
          end
        end
      end
      S_RDATA: begin
        if (cache_data_ack_i) begin
          rd_data_d = cache_rd_data_i;
          state_d   = S_RESP;
        end
      end
      S_WDATA: begin
        if (cache_data_ack_i) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    cache_req_o      = (state_q == S_ADDR);
    cpu_rd_valid_o   = (state_q == S_RESP);
    wbuf_empty_o     = (count_q == '0) && !wr_in_flight;
    pipeline_stall_o = rst_n && ((cpu_rd_req_i && (state_q != S_RESP)) ||
                                 (cpu_wr_req_i && full && !pop));
  end

  assign cache_op_o      = op_q;
  assign cache_offset_o  = addr_q[OFFSET_AW-1:0];
  assign cache_index_o   = addr_q[OFFSET_AW+INDEX_AW-1:OFFSET_AW];
  assign cache_tag_o     = addr_q[ADDR_WIDTH-1:OFFSET_AW+INDEX_AW];
  assign cache_wr_en_o   = be_q;
  assign cache_wr_data_o = data_q;
  assign cpu_rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_core_cache_req_buf.sv
// Bench for core_cache_req_buf: CPU driver tasks, a cache responder checking each request
// against an expected-transaction queue, and a load-data scoreboard.
module tb_core_cache_req_buf;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int IW  = 8;
  localparam int OW  = 4;
  localparam int TW  = AW - IW - OW;
  localparam int PKW = 1 + AW + DW + BW;

  logic          clk, rst_n;
  logic          cpu_rd_req_i, cpu_wr_req_i;
  logic [AW-1:0] cpu_rd_addr_i, cpu_wr_addr_i;
  logic [DW-1:0] cpu_wr_data_i, cpu_rd_data_o;
  logic [BW-1:0] cpu_wr_en_i;
  logic          cpu_rd_valid_o, pipeline_stall_o, wbuf_empty_o;
  logic          cache_req_o, cache_op_o;
  logic [IW-1:0] cache_index_o;
  logic [TW-1:0] cache_tag_o;
  logic [OW-1:0] cache_offset_o;
  logic [BW-1:0] cache_wr_en_o;
  logic [DW-1:0] cache_wr_data_o, cache_rd_data_i;
  logic          cache_addr_ack_i, cache_data_ack_i;

  core_cache_req_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_AW(IW), .OFFSET_AW(OW), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd_req_i(cpu_rd_req_i), .cpu_rd_addr_i(cpu_rd_addr_i),
    .cpu_wr_req_i(cpu_wr_req_i), .cpu_wr_addr_i(cpu_wr_addr_i),
    .cpu_wr_data_i(cpu_wr_data_i), .cpu_wr_en_i(cpu_wr_en_i),
    .cpu_rd_data_o(cpu_rd_data_o), .cpu_rd_valid_o(cpu_rd_valid_o),
    .pipeline_stall_o(pipeline_stall_o), .wbuf_empty_o(wbuf_empty_o),
    .cache_req_o(cache_req_o), .cache_op_o(cache_op_o),
    .cache_index_o(cache_index_o), .cache_tag_o(cache_tag_o), .cache_offset_o(cache_offset_o),
    .cache_wr_en_o(cache_wr_en_o), .cache_wr_data_o(cache_wr_data_o),
    .cache_rd_data_i(cache_rd_data_i),
    .cache_addr_ack_i(cache_addr_ack_i), .cache_data_ack_i(cache_data_ack_i)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [PKW-1:0] exp_q[$];
  logic [DW-1:0]  exp_rd_q[$];
  logic           ack_en    = 1'b1;
  logic           fast      = 1'b0;
  logic           data_hold = 1'b0;
  logic           data_pend = 1'b0;
  logic [DW-1:0]  rd_word   = '0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKW-1:0] pk(input logic op, input logic [AW-1:0] a,
                                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    return {op, a, d, be};
  endfunction

  // Cache responder: checks each accepted request against the expected transaction order
  initial begin
    cache_addr_ack_i = 1'b0;
    cache_data_ack_i = 1'b0;
    cache_rd_data_i  = '0;
    forever begin
      @(negedge clk);
      cache_addr_ack_i = 1'b0;
      cache_data_ack_i = 1'b0;
      cache_rd_data_i  = '0;
      if (!rst_n) begin
        data_pend = 1'b0;
      end else if (data_pend) begin
        if (!data_hold) begin
          cache_data_ack_i = 1'b1;
          cache_rd_data_i  = rd_word;
          data_pend        = 1'b0;
        end
      end else if (cache_req_o && ack_en) begin
        if (exp_q.size() == 0)
          chk("unexp_req", 80'(cache_req_o), 80'(0));
        else
          chk("cache_txn", 80'({cache_op_o, cache_tag_o, cache_index_o, cache_offset_o,
                                cache_wr_data_o, cache_wr_en_o}), 80'(exp_q.pop_front()));
        cache_addr_ack_i = 1'b1;
        if (fast) begin
          cache_data_ack_i = 1'b1;
          cache_rd_data_i  = rd_word;
        end else begin
          data_pend = 1'b1;
        end
      end
    end
  end

  // Load completion scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cpu_rd_valid_o) begin
        if (exp_rd_q.size() == 0) chk("unexp_rd_valid", 80'(cpu_rd_valid_o), 80'(0));
        else                      chk("rd_data", 80'(cpu_rd_data_o), 80'(exp_rd_q.pop_front()));
      end
    end
  end

  task automatic cpu_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be,
                           input logic wait_stall, output int stalls);
    @(negedge clk);
    cpu_wr_req_i  = 1'b1;
    cpu_wr_addr_i = a;
    cpu_wr_data_i = d;
    cpu_wr_en_i   = be;
    #1;
    stalls = 0;
    while (wait_stall && pipeline_stall_o && stalls < 300) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (wait_stall && pipeline_stall_o) chk("store_timeout", 80'(pipeline_stall_o), 80'(0));
    @(posedge clk);
    #1;
    cpu_wr_req_i = 1'b0;
  endtask

  task automatic cpu_load(input logic [AW-1:0] a, input logic [DW-1:0] d, output int stalls);
    @(negedge clk);
    rd_word = d;
    exp_rd_q.push_back(d);
    cpu_rd_req_i  = 1'b1;
    cpu_rd_addr_i = a;
    #1;
    stalls = 0;
    while (pipeline_stall_o && stalls < 300) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (pipeline_stall_o) chk("load_timeout", 80'(pipeline_stall_o), 80'(0));
    @(posedge clk);
    #1;
    cpu_rd_req_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(wbuf_empty_o && !cache_req_o && !data_pend && !cpu_rd_valid_o) && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("idle_reached", 80'(wbuf_empty_o && !cache_req_o), 80'(1));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s, s2, n, reqs;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [BW-1:0] be;

    // Reset with both requests high: stall must stay low
    rst_n = 1'b0;
    cpu_rd_req_i = 1'b1; cpu_rd_addr_i = '0;
    cpu_wr_req_i = 1'b1; cpu_wr_addr_i = '0; cpu_wr_data_i = '0; cpu_wr_en_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 80'(pipeline_stall_o), 80'(0));
    chk("rst_empty", 80'(wbuf_empty_o), 80'(1));
    chk("rst_req", 80'(cache_req_o), 80'(0));
    chk("rst_rd_valid", 80'(cpu_rd_valid_o), 80'(0));
    @(negedge clk);
    rst_n = 1'b1; cpu_rd_req_i = 1'b0; cpu_wr_req_i = 1'b0;
    @(negedge clk);
    chk("post_rst_empty", 80'(wbuf_empty_o), 80'(1));

    // Single read 0x1234 -> tag 0x00001, index 0x23, offset 0x4
    exp_q.push_back(pk(1'b0, 32'h0000_1234, '0, '0));
    cpu_load(32'h0000_1234, 32'hDEAD_BEEF, s);
    chk("t1_stall_cycles", 80'(s), 80'(3));
    wait_idle();

    // Four stores fill the buffer with acks withheld; fifth stalls until a pop
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d  = $urandom;
      be = 4'($urandom_range(1, 15));
      exp_q.push_back(pk(1'b1, 32'h1000 + 32'(i * 4), d, be));
      cpu_store(32'h1000 + 32'(i * 4), d, be, 1'b1, s);
      chk("t2_store_no_stall", 80'(s), 80'(0));
    end
    chk("t2_not_empty", 80'(wbuf_empty_o), 80'(0));
    d = $urandom;
    exp_q.push_back(pk(1'b1, 32'h1010, d, 4'hc));
    @(negedge clk);
    cpu_wr_req_i = 1'b1; cpu_wr_addr_i = 32'h1010; cpu_wr_data_i = d; cpu_wr_en_i = 4'hc;
    #1;
    chk("t2_full_stall", 80'(pipeline_stall_o), 80'(1));
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("t2_full_hold", 80'(pipeline_stall_o), 80'(1));
    end
    ack_en = 1'b1;
    n = 0;
    while (pipeline_stall_o && n < 300) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("t2_fifth_accept", 80'(pipeline_stall_o), 80'(0));
    @(posedge clk);
    #1;
    cpu_wr_req_i = 1'b0;
    wait_idle();
    chk("t2_drained_empty", 80'(wbuf_empty_o), 80'(1));

    // Hazarded load waits for the older store to 0x100 to complete
    d = $urandom;
    exp_q.push_back(pk(1'b1, 32'h100, d, 4'h3));
    exp_q.push_back(pk(1'b0, 32'h102, '0, '0));
    cpu_store(32'h100, d, 4'h3, 1'b1, s);
    chk("t3_store_no_stall", 80'(s), 80'(0));
    cpu_load(32'h102, $urandom, s);
    chk("t3_hazard_stall", 80'(s), 80'(6));
    wait_idle();

    // Unhazarded load bypasses the buffered store
    d = $urandom;
    exp_q.push_back(pk(1'b0, 32'h108, '0, '0));
    exp_q.push_back(pk(1'b1, 32'h100, d, 4'h3));
    cpu_store(32'h100, d, 4'h3, 1'b1, s);
    cpu_load(32'h108, $urandom, s);
    chk("t3_bypass_stall", 80'(s), 80'(3));
    wait_idle();

    // Same-cycle store and load to 0x200: store goes to the cache first
    d = $urandom;
    exp_q.push_back(pk(1'b1, 32'h200, d, 4'hf));
    exp_q.push_back(pk(1'b0, 32'h200, '0, '0));
    fork
      cpu_store(32'h200, d, 4'hf, 1'b0, s2);
      cpu_load(32'h200, $urandom, s);
    join
    chk("t4_same_cycle_stall", 80'(s), 80'(7));
    wait_idle();

    // Address and data ack together on a read: RESP follows ADDR directly
    fast = 1'b1;
    exp_q.push_back(pk(1'b0, 32'h3000, '0, '0));
    cpu_load(32'h3000, $urandom, s);
    chk("t5_fast_stall", 80'(s), 80'(2));
    fast = 1'b0;
    wait_idle();

    // Reset while a read waits for data and two stores are buffered
    data_hold = 1'b1;
    exp_q.push_back(pk(1'b0, 32'h500, '0, '0));
    @(negedge clk);
    cpu_rd_req_i = 1'b1; cpu_rd_addr_i = 32'h500;
    cpu_store(32'h600, $urandom, 4'hf, 1'b0, s);
    cpu_store(32'h604, $urandom, 4'h1, 1'b0, s);
    @(negedge clk);
    chk("t6_busy", 80'(wbuf_empty_o), 80'(0));
    chk("t6_rdata_no_req", 80'(cache_req_o), 80'(0));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", 80'(pipeline_stall_o), 80'(0));
    @(negedge clk);
    chk("t6_empty", 80'(wbuf_empty_o), 80'(1));
    chk("t6_outputs", 80'({cache_req_o, cache_op_o, cache_tag_o, cache_index_o, cache_offset_o,
                           cache_wr_en_o, cache_wr_data_o, cpu_rd_valid_o, cpu_rd_data_o}), 80'(0));
    @(negedge clk);
    rst_n = 1'b1; cpu_rd_req_i = 1'b0; data_hold = 1'b0;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (cache_req_o) reqs++;
    end
    chk("t6_no_req_after_rst", 80'(reqs), 80'(0));

    // Random stores then random loads
    for (int i = 0; i < 6; i++) begin
      d  = $urandom;
      be = 4'($urandom_range(1, 15));
      exp_q.push_back(pk(1'b1, 32'h2000 + 32'(i * 4), d, be));
      cpu_store(32'h2000 + 32'(i * 4), d, be, 1'b1, s);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      a    = 32'h4000 + 32'($urandom_range(0, 255) * 4);
      fast = 1'($urandom_range(0, 1));
      exp_q.push_back(pk(1'b0, a, '0, '0));
      cpu_load(a, $urandom, s);
      chk("t7_load_stall", 80'(s), fast ? 80'(2) : 80'(3));
    end
    fast = 1'b0;
    wait_idle();

    chk("exp_q_drained", 80'(exp_q.size()), 80'(0));
    chk("exp_rd_q_drained", 80'(exp_rd_q.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
